reg_file_2r1w: RTL and testbench
================================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits per entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: address bits per port.
REQ-003 SHALL have parameter DEPTH, default 8: number of entries, constrained to 2 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports WrEn (in, 1), WrAddr (in, ADDR_WIDTH) and WrData (in, DATA_WIDTH): the write port.
REQ-007 SHALL have ports RdEn0 (in, 1) and RdAddr0 (in, ADDR_WIDTH): read request, port 0.
REQ-008 SHALL have ports RdData0 (out, DATA_WIDTH) and RdValid0 (out, 1): read response, port 0.
REQ-009 SHALL have ports RdEn1, RdAddr1, RdData1 and RdValid1: port 1, identical in widths and directions to port 0.
REQ-010 SHALL have ports Clr (in, 1), Busy (out, 1) and AddrErr (out, 1): clear request, clear-in-progress flag, and address-range error pulse.

Function
REQ-011 SHALL write WrData to the entry at WrAddr on the rising edge when WrEn=1, Busy=0 and WrAddr<DEPTH.
REQ-012 SHALL respond to RdEnN=1 with Busy=0 one cycle later: RdDataN = entry at RdAddrN and RdValidN=1, asserted for exactly one cycle.
REQ-013 SHALL deassert RdValidN when no read is accepted on port N, and RdDataN SHALL hold its last value; it is not zeroed.
REQ-014 SHALL accept simultaneous read and write in the same cycle; the two read ports operate fully independently, including reading the same address.
REQ-015 SHALL be write-first: a read whose address equals the accepted WrAddr in the same cycle returns the new WrData.
REQ-016 SHALL treat an address >= DEPTH as out of range: the write is dropped; the read returns all zeros with RdValidN=1.
REQ-017 SHALL pulse AddrErr for one cycle, aligned with RdValid timing, for any accepted access whose address is out of range.
REQ-018 SHALL implement a clear FSM with two states, IDLE and CLEAR, and a pointer of width ADDR_WIDTH.
REQ-019 SHALL, on Clr=1 in IDLE, enter CLEAR with pointer=0; in CLEAR, write 0 to the entry at the pointer each cycle and increment the pointer.
REQ-020 SHALL return the FSM to IDLE after clearing entry DEPTH-1; the clear therefore lasts exactly DEPTH cycles.
REQ-021 SHALL drive Busy=1 exactly while the FSM is in CLEAR.
REQ-022 SHALL ignore Clr while in CLEAR.
REQ-023 SHALL, while Busy=1, drop writes, keep RdValidN=0 and not raise AddrErr.
REQ-024 SHALL, when Clr and WrEn are both asserted in IDLE, perform the write, and the clear then overwrites it; the end state is all zeros.

Reset
REQ-025 SHALL, while RST=1 and regardless of clock, force all entries, RdData0/1, RdValid0/1, AddrErr and Busy to 0, the FSM to IDLE and the pointer to 0.
REQ-026 SHALL abort any in-progress clear when reset is asserted, and begin operation in IDLE from the first rising CLK edge after RST deasserts.

Configuration
REQ-027 SHALL, when the macro REG_FILE_PARITY_EN is defined, store one even-parity bit per entry, computed on write; clear and reset store parity 0.
REQ-028 SHALL, with REG_FILE_PARITY_EN defined, add input ParInj (1 bit): when set with an accepted write, the inverted parity is stored.
REQ-029 SHALL, with REG_FILE_PARITY_EN defined, add outputs ParErr0 and ParErr1 (1 bit each), asserted together with RdValidN when the stored parity mismatches; they reset to 0.
REQ-030 SHALL, without REG_FILE_PARITY_EN, have no parity storage and no ParInj or ParErr ports; behaviour is otherwise identical.

Structure
REQ-031 SHALL place the FSM state type (IDLE, CLEAR) and the default DATA_WIDTH, ADDR_WIDTH and DEPTH constants in the shared package reg_file_pkg.
REQ-032 SHALL implement the clear FSM and pointer in the sub-module reg_file_clr_fsm (outputs Busy, clear address, clear write enable); the storage and read ports stay in the top module.

Verification
REQ-033 SHALL cover: reset, then write 0xA5A5 to address 3, then read port 0 address 3 -> RdData0=0xA5A5 with RdValid0=1 on the next cycle only.
REQ-034 SHALL cover: same-cycle write 0x1234 to address 5 with both ports reading address 5 -> both ports return 0x1234 one cycle later.
REQ-035 SHALL cover: with DEPTH=6, write to address 7, then read address 7 -> memory unchanged, RdData=0, RdValid=1, AddrErr pulses once.
REQ-036 SHALL cover: fill all entries, then pulse Clr together with a write -> Busy=1 for exactly DEPTH cycles; reads during Busy give RdValid=0; afterwards every entry reads 0.
REQ-037 SHALL cover: assert RST for one cycle at the fourth cycle of a clear -> Busy=0 immediately, all outputs 0, and normal write/read works afterwards.
REQ-038 SHALL cover, with REG_FILE_PARITY_EN defined: write 0x0001 with ParInj=1, then read -> ParErr0=1 with RdValid0; a normal write then read -> ParErr0=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared clear-FSM state type and default sizes for the 2R1W register file
package reg_file_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DEPTH = 8;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
endpackage

// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: write, dual read, clear and status signals; parity pins only with REG_FILE_PARITY_EN
interface reg_file_2r1w_if import reg_file_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  WrEn;
  logic [ADDR_WIDTH-1:0] WrAddr;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  RdEn0;
  logic [ADDR_WIDTH-1:0] RdAddr0;
  logic [DATA_WIDTH-1:0] RdData0;
  logic                  RdValid0;
  logic                  RdEn1;
  logic [ADDR_WIDTH-1:0] RdAddr1;
  logic [DATA_WIDTH-1:0] RdData1;
  logic                  RdValid1;
  logic                  Clr;
  logic                  Busy;
  logic                  AddrErr;
`ifdef REG_FILE_PARITY_EN
  logic                  ParInj;
  logic                  ParErr0;
  logic                  ParErr1;
`endif
  modport master (
    output WrEn, WrAddr, WrData, RdEn0, RdAddr0, RdEn1, RdAddr1, Clr,
`ifdef REG_FILE_PARITY_EN
    output ParInj,
    input  ParErr0, ParErr1,
`endif
    input  RdData0, RdValid0, RdData1, RdValid1, Busy, AddrErr
  );
  modport slave (
    input  WrEn, WrAddr, WrData, RdEn0, RdAddr0, RdEn1, RdAddr1, Clr,
`ifdef REG_FILE_PARITY_EN
    input  ParInj,
    output ParErr0, ParErr1,
`endif
    output RdData0, RdValid0, RdData1, RdValid1, Busy, AddrErr
  );
endinterface

// File: rtl/reg_file_clr_fsm.sv
// reg_file_clr_fsm: walks a pointer over every entry once, zeroing one entry per cycle
module reg_file_clr_fsm import reg_file_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  clr_we_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  // state and pointer registers; reset aborts any clear in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  // start from entry 0 on request; return to IDLE once the last entry is zeroed
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (clr_i) begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    end else begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST) begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    end
  end
  assign busy_o     = state_q == CLEAR;
  assign clr_we_o   = state_q == CLEAR;
  assign clr_addr_o = ptr_q;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: write-first register file, one write and two registered read ports, background clear; parity with REG_FILE_PARITY_EN
module reg_file_2r1w import reg_file_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input logic           CLK,
  input logic           RST,
  reg_file_2r1w_if.slave bus
);
  localparam int SLOTS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  logic [SLOTS-1:0][DATA_WIDTH-1:0] mem_q;
  logic                             busy, clr_we;
  logic [ADDR_WIDTH-1:0]            clr_addr;
  logic                             wr_acc, wr_ok, addr_err_d, addr_err_q;
  logic [1:0]                       rd_en, rd_acc, rd_in, rd_valid_q;
  logic [1:0][ADDR_WIDTH-1:0]       rd_addr;
  logic [1:0][DATA_WIDTH-1:0]       rd_data_d, rd_data_q;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  reg_file_clr_fsm #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_clr (
    .clk       (CLK),
    .rst       (RST),
    .clr_i     (bus.Clr),
    .busy_o    (busy),
    .clr_addr_o(clr_addr),
    .clr_we_o  (clr_we)
  );

  assign rd_en      = {bus.RdEn1, bus.RdEn0};
  assign rd_addr    = {bus.RdAddr1, bus.RdAddr0};
  assign wr_acc     = bus.WrEn && !busy;
  assign wr_ok      = wr_acc && in_range(bus.WrAddr);
  assign rd_acc     = busy ? 2'b00 : rd_en;
  assign addr_err_d = (wr_acc && !in_range(bus.WrAddr)) || |(rd_acc & ~rd_in);

  // read data: zero when out of range, bypass a same-cycle write, else the stored entry
  always_comb begin
    rd_in     = '0;
    rd_data_d = '0;
    for (int n = 0; n < 2; n++) begin
      rd_in[n]     = in_range(rd_addr[n]);
      rd_data_d[n] = !rd_in[n] ? '0 :
                     (wr_ok && bus.WrAddr == rd_addr[n]) ? bus.WrData : mem_q[rd_addr[n]];
    end
  end

  // storage: the clear sweep has priority, though writes are already blocked while busy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mem_q <= '0;
    else if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr_ok) mem_q[bus.WrAddr] <= bus.WrData;
  end

  // registered read responses; data holds its last value between accepted reads
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      addr_err_q <= addr_err_d;
      for (int n = 0; n < 2; n++) if (rd_acc[n]) rd_data_q[n] <= rd_data_d[n];
    end
  end

  assign bus.RdData0  = rd_data_q[0];
  assign bus.RdData1  = rd_data_q[1];
  assign bus.RdValid0 = rd_valid_q[0];
  assign bus.RdValid1 = rd_valid_q[1];
  assign bus.AddrErr  = addr_err_q;
  assign bus.Busy     = busy;

`ifdef REG_FILE_PARITY_EN
  logic [SLOTS-1:0] par_q;
  logic             wr_par;
  logic [1:0]       rd_par, par_err_d, par_err_q;
  assign wr_par = ^bus.WrData ^ bus.ParInj;
  // stored parity follows the same bypass path as the data
  always_comb begin
    rd_par    = '0;
    par_err_d = '0;
    for (int n = 0; n < 2; n++) begin
      rd_par[n]    = !rd_in[n] ? 1'b0 :
                     (wr_ok && bus.WrAddr == rd_addr[n]) ? wr_par : par_q[rd_addr[n]];
      par_err_d[n] = rd_par[n] != ^rd_data_d[n];
    end
  end
  // parity storage, zeroed by clear and reset like the data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) par_q <= '0;
    else if (clr_we) par_q[clr_addr] <= 1'b0;
    else if (wr_ok) par_q[bus.WrAddr] <= wr_par;
  end
  // parity error flags pulse alongside the matching read valid
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) par_err_q <= '0;
    else par_err_q <= rd_acc & par_err_d;
  end
  assign bus.ParErr0 = par_err_q[0];
  assign bus.ParErr1 = par_err_q[1];
`endif
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed vectors for the 2R1W register file (DEPTH=6 so addresses 6 and 7 are out of range)
module tb_reg_file_2r1w;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  int          n_vec = 0;
  int          n_err = 0;
  int          cnt;
  logic [15:0] model [8];

  reg_file_2r1w_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();
  reg_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(6)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic idle();
    bus.WrEn  = 1'b0;
    bus.RdEn0 = 1'b0;
    bus.RdEn1 = 1'b0;
    bus.Clr   = 1'b0;
`ifdef REG_FILE_PARITY_EN
    bus.ParInj = 1'b0;
`endif
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.WrEn   = 1'b1;
    bus.WrAddr = a;
    bus.WrData = d;
    cyc();
    bus.WrEn = 1'b0;
  endtask

  task automatic read_both(input logic [2:0] a0, input logic [2:0] a1, input string tag);
    bus.RdEn0   = 1'b1;
    bus.RdAddr0 = a0;
    bus.RdEn1   = 1'b1;
    bus.RdAddr1 = a1;
    cyc();
    bus.RdEn0 = 1'b0;
    bus.RdEn1 = 1'b0;
    check({tag, "_d0"}, bus.RdData0, model[a0]);
    check({tag, "_d1"}, bus.RdData1, model[a1]);
    check({tag, "_v"}, {bus.RdValid1, bus.RdValid0}, 2'b11);
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < 6; i += 2) read_both(3'(i), 3'(i + 1), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    bus.WrAddr = '0; bus.WrData = '0; bus.RdAddr0 = '0; bus.RdAddr1 = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (2) cyc();
    check("rst_busy", bus.Busy, 0);
    check("rst_valid", {bus.RdValid1, bus.RdValid0}, 0);
    check("rst_err", bus.AddrErr, 0);
    check("rst_data", {bus.RdData1, bus.RdData0}, 0);
    RST = 1'b0;

    wr(3, 16'hA5A5); model[3] = 16'hA5A5;
    bus.RdEn0 = 1'b1; bus.RdAddr0 = 3;
    cyc();
    bus.RdEn0 = 1'b0;
    check("rd3_data", bus.RdData0, 16'hA5A5);
    check("rd3_valid", bus.RdValid0, 1);
    check("rd3_valid1", bus.RdValid1, 0);
    cyc();
    check("rd3_valid_drop", bus.RdValid0, 0);
    check("rd3_hold", bus.RdData0, 16'hA5A5);

    bus.WrEn = 1'b1; bus.WrAddr = 5; bus.WrData = 16'h1234;
    bus.RdEn0 = 1'b1; bus.RdAddr0 = 5; bus.RdEn1 = 1'b1; bus.RdAddr1 = 5;
    cyc();
    idle(); model[5] = 16'h1234;
    check("wf_d0", bus.RdData0, 16'h1234);
    check("wf_d1", bus.RdData1, 16'h1234);
    check("wf_v", {bus.RdValid1, bus.RdValid0}, 2'b11);
    check("wf_err", bus.AddrErr, 0);

    wr(7, 16'hBEEF);
    check("oor_wr_err", bus.AddrErr, 1);
    cyc();
    check("oor_err_drop", bus.AddrErr, 0);
    bus.RdEn0 = 1'b1; bus.RdAddr0 = 7; bus.RdEn1 = 1'b1; bus.RdAddr1 = 3;
    cyc();
    idle();
    check("oor_rd_data", bus.RdData0, 0);
    check("oor_rd_valid", bus.RdValid0, 1);
    check("oor_other_port", bus.RdData1, 16'hA5A5);
    check("oor_rd_err", bus.AddrErr, 1);
    cyc();
    check("oor_rd_err_drop", bus.AddrErr, 0);
    scan("oor_mem");

    for (int i = 0; i < 6; i++) begin
      model[i] = 16'h1111 * 16'(i + 1);
      wr(3'(i), model[i]);
    end
    read_both(0, 5, "fill");
    bus.Clr = 1'b1; bus.WrEn = 1'b1; bus.WrAddr = 2; bus.WrData = 16'hFFFF;
    cyc();
    check("clr_busy_start", bus.Busy, 1);
    cnt = 0;
    while (bus.Busy && cnt < 20) begin
      bus.RdEn0 = 1'b1; bus.RdAddr0 = 0; bus.RdEn1 = 1'b1; bus.RdAddr1 = 7;
      bus.WrEn = 1'b1; bus.WrAddr = 4; bus.WrData = 16'h7777;
      cyc();
      cnt++;
      check("clr_rd_valid", {bus.RdValid1, bus.RdValid0}, 0);
      check("clr_err", bus.AddrErr, 0);
    end
    idle();
    check("clr_len", cnt, 6);
    for (int i = 0; i < 8; i++) model[i] = '0;
    scan("clr_mem");

    wr(1, 16'hCAFE); model[1] = 16'hCAFE;
    read_both(1, 1, "pre_rst");
    bus.Clr = 1'b1;
    cyc();
    bus.Clr = 1'b0;
    check("rc_busy", bus.Busy, 1);
    repeat (3) cyc();
    check("rc_busy4", bus.Busy, 1);
    RST = 1'b1;
    #1;
    check("rc_busy_rst", bus.Busy, 0);
    check("rc_data_rst", {bus.RdData1, bus.RdData0}, 0);
    check("rc_valid_rst", {bus.RdValid1, bus.RdValid0}, 0);
    check("rc_err_rst", bus.AddrErr, 0);
    cyc();
    RST = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    wr(2, 16'h5A5A); model[2] = 16'h5A5A;
    check("rc_idle", bus.Busy, 0);
    read_both(2, 1, "post_rst");

`ifdef REG_FILE_PARITY_EN
    bus.ParInj = 1'b1;
    wr(0, 16'h0001);
    bus.ParInj = 1'b0;
    bus.RdEn0 = 1'b1; bus.RdAddr0 = 0;
    cyc();
    idle();
    check("par_inj_err", bus.ParErr0, 1);
    check("par_inj_valid", bus.RdValid0, 1);
    check("par_inj_data", bus.RdData0, 16'h0001);
    cyc();
    check("par_err_drop", bus.ParErr0, 0);
    wr(0, 16'h0003);
    bus.RdEn0 = 1'b1; bus.RdAddr0 = 0;
    cyc();
    idle();
    check("par_ok_err", bus.ParErr0, 0);
    check("par_ok_data", bus.RdData0, 16'h0003);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
